// File: rtl/main_mem_pipelined.sv
// main_mem_pipelined
//   Word-addressed main-memory responder for the cache fill/write-back
//   controllers. Accepts one request per cycle. Reads return after a fixed
//   LATENCY, flagged by data_valid, strictly in issue order. Writes commit at
//   the issue edge and produce no response.
//
// Ports
//   clk         clock, all state updates on posedge
//   rst_n       synchronous active-low reset (array contents are kept)
//   enable      request valid this cycle
//   wr          1 = write, 0 = read (ignored when enable = 0)
//   addr        byte address, addr[0] ignored
//   data_in     write data, sampled when enable & wr
//   data_out    read data, 16'h0000 whenever data_valid = 0
//   data_valid  read response valid this cycle
//   pending     number of reads issued but not yet returned
module main_mem_pipelined #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           data_in,
  output logic [15:0]           data_out,
  output logic                  data_valid,
  output logic [3:0]            pending
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 1);

  logic [15:0]           mem [0:DEPTH-1];
  logic [ADDR_WIDTH-2:0] word;
  logic                  unused_addr_lsb;
  logic                  issue;
  logic                  commit;

  // Index 0 is the registered array read taken at the issue edge; indices
  // 1..LATENCY are the response stages, so stage LATENCY is valid exactly
  // LATENCY edges after the issue edge.
  logic [LATENCY:0]      valid_reg;
  logic [15:0]           data_reg [0:LATENCY];
  logic [3:0]            pending_reg;

  assign word            = addr[ADDR_WIDTH-1:1];
  assign unused_addr_lsb = addr[0];

  // Requests are ignored during a reset cycle.
  assign issue  = rst_n & enable & ~wr;
  assign commit = rst_n & enable & wr;

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[word] <= data_in;
    end
  end

  // Registered read: captures the value present at the issue edge, so a
  // write on any later edge cannot leak into this response.
  always_ff @(posedge clk) begin
    if (issue) begin
      data_reg[0] <= mem[word];
    end
  end

  // Data stages carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    for (int i = 1; i <= LATENCY; i++) begin
      data_reg[i] <= data_reg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= {valid_reg[LATENCY-1:0], issue};
    end
  end

  // In-flight count covers index 0..LATENCY-1; a read leaves the count on
  // the edge it reaches the output stage. Bounded by LATENCY, never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg <= 4'd0;
    end else begin
      pending_reg <= pending_reg + {3'b000, issue} - {3'b000, valid_reg[LATENCY-1]};
    end
  end

  assign data_valid = valid_reg[LATENCY];
  assign data_out   = valid_reg[LATENCY] ? data_reg[LATENCY] : 16'h0000;
  assign pending    = pending_reg;

endmodule

// File: tb/tb_main_mem_pipelined.sv
// tb_main_mem_pipelined
//   Directed bench for main_mem_pipelined. Two instances share the request
//   inputs: dut_a with LATENCY=4 and dut_b with LATENCY=1. Outputs are
//   sampled 1 ns after each rising edge.
module tb_main_mem_pipelined;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;

  logic [15:0] dout_a, dout_b;
  logic        dv_a, dv_b;
  logic [3:0]  pend_a, pend_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  main_mem_pipelined #(.ADDR_WIDTH(16), .LATENCY(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(dout_a), .data_valid(dv_a), .pending(pend_a)
  );

  main_mem_pipelined #(.ADDR_WIDTH(16), .LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(dout_b), .data_valid(dv_b), .pending(pend_b)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One request per call; returns 1 ns after the edge that sampled it.
  task automatic op(input logic r, input logic e, input logic w,
                    input logic [15:0] a, input logic [15:0] d);
    rst_n   = r;
    enable  = e;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
    cyc++;
    $display("txn %0d rst_n=%0b en=%0b wr=%0b addr=%h din=%h | A dv=%0b do=%h p=%0d | B dv=%0b do=%h p=%0d",
             cyc, r, e, w, a, d, dv_a, dout_a, pend_a, dv_b, dout_b, pend_b);
  endtask

  task automatic idle();
    op(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    op(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd_word(input logic [15:0] a);
    op(1'b1, 1'b1, 1'b0, a, 16'h0000);
  endtask

  initial begin
    int peak;
    int exp_p;
    logic exp_dv;

    rst_n = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;

    // Reset state
    op(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    op(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rst_dv_a",   {15'd0, dv_a}, 16'd0);
    chk("rst_do_a",   dout_a, 16'h0000);
    chk("rst_pend_a", {12'd0, pend_a}, 16'd0);
    chk("rst_dv_b",   {15'd0, dv_b}, 16'd0);
    chk("rst_pend_b", {12'd0, pend_b}, 16'd0);

    // Test 1: single read, latency 4
    wr_word(16'h0010, 16'hBEEF);
    rd_word(16'h0010);
    chk("t1_pend_issue", {12'd0, pend_a}, 16'd1);
    for (int k = 1; k <= 3; k++) begin
      idle();
      chk("t1_dv_early", {15'd0, dv_a}, 16'd0);
      chk("t1_pend",     {12'd0, pend_a}, 16'd1);
    end
    idle();
    chk("t1_dv",   {15'd0, dv_a}, 16'd1);
    chk("t1_data", dout_a, 16'hBEEF);
    chk("t1_pend_done", {12'd0, pend_a}, 16'd0);
    idle();
    chk("t1_dv_after", {15'd0, dv_a}, 16'd0);
    chk("t1_do_zero",  dout_a, 16'h0000);

    // Test 2: write then read of the odd byte address of the same word
    wr_word(16'h0040, 16'h1234);
    rd_word(16'h0041);
    for (int k = 1; k <= 3; k++) begin
      idle();
      chk("t2_dv_early", {15'd0, dv_a}, 16'd0);
    end
    idle();
    chk("t2_dv",   {15'd0, dv_a}, 16'd1);
    chk("t2_data", dout_a, 16'h1234);

    // Test 3: eight back-to-back reads
    for (int i = 0; i < 8; i++) wr_word(16'h0100 + 16'(2 * i), 16'hA000 + 16'(i));
    idle();
    peak = 0;
    for (int k = 0; k <= 12; k++) begin
      if (k < 8) rd_word(16'h0100 + 16'(2 * k));
      else idle();
      exp_dv = (k >= 4) && (k <= 11);
      exp_p  = 0;
      for (int i = 0; i < 8; i++) if (i <= k && i + 4 > k) exp_p++;
      chk("t3_dv", {15'd0, dv_a}, {15'd0, exp_dv});
      chk("t3_data", dout_a, exp_dv ? 16'hA000 + 16'(k - 4) : 16'h0000);
      chk("t3_pend", {12'd0, pend_a}, 16'(exp_p));
      if (int'(pend_a) > peak) peak = int'(pend_a);
    end
    chk("t3_peak", 16'(peak), 16'd4);

    // Test 4: read must not see a write issued on the following edge
    wr_word(16'h0020, 16'h1111);
    for (int k = 0; k <= 7; k++) begin
      if (k == 0) rd_word(16'h0020);
      else if (k == 1) wr_word(16'h0020, 16'h2222);
      else if (k == 2) rd_word(16'h0020);
      else idle();
      exp_dv = (k == 4) || (k == 6);
      chk("t4_dv", {15'd0, dv_a}, {15'd0, exp_dv});
      if (k == 4) chk("t4_old", dout_a, 16'h1111);
      if (k == 6) chk("t4_new", dout_a, 16'h2222);
    end

    // Test 5: reset drops in-flight reads and ignores enable; array persists
    wr_word(16'h0080, 16'h5555);
    rd_word(16'h0080);
    rd_word(16'h0080);
    op(1'b0, 1'b1, 1'b1, 16'h0080, 16'hDEAD);
    chk("t5_pend_rst", {12'd0, pend_a}, 16'd0);
    for (int k = 3; k <= 8; k++) begin
      idle();
      chk("t5_dv_none", {15'd0, dv_a}, 16'd0);
      chk("t5_pend",    {12'd0, pend_a}, 16'd0);
    end
    rd_word(16'h0080);
    for (int k = 1; k <= 3; k++) idle();
    idle();
    chk("t5_dv",      {15'd0, dv_a}, 16'd1);
    chk("t5_persist", dout_a, 16'h5555);

    // Test 6: LATENCY=1 instance, alternating read/idle
    idle();
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) rd_word(16'h0100 + 16'(k));
      else idle();
      chk("t6_dv", {15'd0, dv_b}, (k % 2 == 1) ? 16'd1 : 16'd0);
      if (k % 2 == 1) chk("t6_data", dout_b, 16'hA000 + 16'((k - 1) / 2));
      chk("t6_pend", {12'd0, pend_b}, (k % 2 == 0) ? 16'd1 : 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
